// File: rtl/audio_pkg.sv
// Shared types and defaults for the on-board audio path controller.
// Optional mic level meter is built only when MIC_LEVEL_EN is defined.
package audio_pkg;

   typedef enum logic [1:0] {
      OFF  = 2'd0,
      MUTE = 2'd1,
      PLAY = 2'd2
   } audState_t;

   localparam logic SRC_MIC   = 1'b0;
   localparam logic SRC_TIMER = 1'b1;

   localparam int unsigned CLK_DIV_DEF     = 32;
   localparam int unsigned MUTE_CYCLES_DEF = 1024;
   localparam int unsigned SYNC_STAGES_DEF = 3;

   // A full window of ones (256) does not fit in 8 bits; clamp it.
   function automatic logic [7:0] satLevel(input logic [8:0] ones);
      return ones[8] ? 8'hFF : ones[7:0];
   endfunction

endpackage

// File: rtl/pdm_clk_gen.sv
// PDM microphone clock divider, micData synchronizer and sample strobe.
// The divider free-runs in every controller state.
module pdm_clk_gen
   import audio_pkg::*;
#(
   parameter int unsigned CLK_DIV     = CLK_DIV_DEF,
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
)(
   input  logic clk_100MHz,
   input  logic sysreset_n,
   input  logic micData,
   output logic micClk,
   output logic pdmBit,
   output logic pdmValid
);

   localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned HALF  = CLK_DIV / 2;

   logic [DIV_W-1:0]       divCnt;
   logic [SYNC_STAGES-1:0] syncQ;
   logic                   divWrap_c;

   assign divWrap_c = (divCnt == DIV_W'(CLK_DIV - 1));

   // Divider, clock high for the first half of each period.
   always_ff @(posedge clk_100MHz or negedge sysreset_n) begin
      if (!sysreset_n) begin
         divCnt <= '0;
         micClk <= 1'b0;
      end else begin
         divCnt <= divWrap_c ? '0 : divCnt + DIV_W'(1);
         micClk <= (divCnt < DIV_W'(HALF));
      end
   end

   // micData is asynchronous to clk_100MHz; sample only the last stage.
   always_ff @(posedge clk_100MHz or negedge sysreset_n) begin
      if (!sysreset_n) begin
         syncQ    <= '0;
         pdmBit   <= 1'b0;
         pdmValid <= 1'b0;
      end else begin
         syncQ    <= {syncQ[SYNC_STAGES-2:0], micData};
         pdmValid <= divWrap_c;
         if (divWrap_c) begin
            pdmBit <= syncQ[SYNC_STAGES-1];
         end
      end
   end

endmodule

// File: rtl/audio_path_ctrl.sv
// Audio path sequencer: mutes AUD_PWM around amplifier enable and source
// switches. Define MIC_LEVEL_EN to build the mic ones-density meter.
module audio_path_ctrl
   import audio_pkg::*;
#(
   parameter int unsigned CLK_DIV     = CLK_DIV_DEF,
   parameter int unsigned MUTE_CYCLES = MUTE_CYCLES_DEF,
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
)(
   input  logic       clk_100MHz,
   input  logic       sysreset_n,
   input  logic       micData,
   input  logic       timer_pwm,
   input  logic       enable,
   input  logic       src_sel,
   output logic       micClk,
   output logic       micLRSel,
   output logic       AUD_PWM,
   output logic       AUD_SD,
   output logic       pdm_bit,
   output logic       pdm_valid,
   output logic       active_src,
   output logic       busy,
   output logic [7:0] mic_level
);

   localparam int unsigned MUTE_W = $clog2(MUTE_CYCLES);

   audState_t         state;
   logic [MUTE_W-1:0] muteCnt;
   logic              srcSelQ;
   logic              muteDone_c;
   logic              srcToggle_c;
   logic              playSample_c;

   assign micLRSel = 1'b1;

   pdm_clk_gen #(
      .CLK_DIV     (CLK_DIV),
      .SYNC_STAGES (SYNC_STAGES)
   ) uPdmClkGen (
      .clk_100MHz (clk_100MHz),
      .sysreset_n (sysreset_n),
      .micData    (micData),
      .micClk     (micClk),
      .pdmBit     (pdm_bit),
      .pdmValid   (pdm_valid)
   );

   assign muteDone_c  = (muteCnt == MUTE_W'(MUTE_CYCLES - 1));
   assign srcToggle_c = (src_sel != srcSelQ);

   // Value AUD_PWM takes when (re)entering or staying in PLAY.
   assign playSample_c = (src_sel == SRC_TIMER) ? timer_pwm : pdm_bit;

   // Sequencer; outputs are registered from the state being entered.
   always_ff @(posedge clk_100MHz or negedge sysreset_n) begin
      if (!sysreset_n) begin
         state      <= OFF;
         muteCnt    <= '0;
         srcSelQ    <= 1'b0;
         active_src <= SRC_MIC;
         AUD_PWM    <= 1'b0;
         AUD_SD     <= 1'b0;
         busy       <= 1'b0;
      end else begin
         srcSelQ <= src_sel;
         if (!enable) begin
            state   <= OFF;
            muteCnt <= '0;
            AUD_PWM <= 1'b0;
            AUD_SD  <= 1'b0;
            busy    <= 1'b1;
         end else begin
            case (state)
               OFF: begin
                  state   <= MUTE;
                  muteCnt <= '0;
                  AUD_PWM <= 1'b0;
                  AUD_SD  <= 1'b1;
                  busy    <= 1'b1;
               end
               MUTE: begin
                  AUD_SD <= 1'b1;
                  if (srcToggle_c) begin
                     muteCnt <= '0;
                     AUD_PWM <= 1'b0;
                     busy    <= 1'b1;
                  end else if (muteDone_c) begin
                     state      <= PLAY;
                     active_src <= src_sel;
                     AUD_PWM    <= playSample_c;
                     busy       <= 1'b0;
                  end else begin
                     muteCnt <= muteCnt + MUTE_W'(1);
                     AUD_PWM <= 1'b0;
                     busy    <= 1'b1;
                  end
               end
               PLAY: begin
                  AUD_SD <= 1'b1;
                  if (src_sel != active_src) begin
                     state   <= MUTE;
                     muteCnt <= '0;
                     AUD_PWM <= 1'b0;
                     busy    <= 1'b1;
                  end else begin
                     AUD_PWM <= (active_src == SRC_TIMER) ? timer_pwm : pdm_bit;
                     busy    <= 1'b0;
                  end
               end
               default: begin
                  state   <= OFF;
                  muteCnt <= '0;
                  AUD_PWM <= 1'b0;
                  AUD_SD  <= 1'b0;
                  busy    <= 1'b1;
               end
            endcase
         end
      end
   end

`ifdef MIC_LEVEL_EN
   logic [7:0] sampleCnt;
   logic [8:0] onesCnt;
   logic [7:0] levelQ;

   // Each window starts with the sample that closed the previous one.
   always_ff @(posedge clk_100MHz or negedge sysreset_n) begin
      if (!sysreset_n) begin
         sampleCnt <= '0;
         onesCnt   <= '0;
         levelQ    <= '0;
      end else if (pdm_valid) begin
         sampleCnt <= sampleCnt + 8'd1;
         if (sampleCnt == 8'hFF) begin
            levelQ  <= satLevel(onesCnt);
            onesCnt <= {8'd0, pdm_bit};
         end else begin
            onesCnt <= onesCnt + {8'd0, pdm_bit};
         end
      end
   end

   assign mic_level = levelQ;
`else
   assign mic_level = 8'd0;
`endif

endmodule
